// File: rtl/add_pipe_pkg.sv
// add_pipe shared helpers.
// Slice-count arithmetic used by the pipelined adder.
package add_pipe_pkg;

    function automatic int stages_of(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/add_pipe_chunk.sv
// Ripple slice of the pipelined adder.
// add_1_bit is the full-adder cell; add_chunk chains W of them.
module add_1_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module add_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb
);
    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        add_1_bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[W];
    assign c_msb = c[W-1];
endmodule

// File: rtl/add_pipe.sv
// Pipelined add/sub: one CHUNK-bit ripple slice per stage,
// skewed operands, deskewed results, global valid/ready stall.
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = stages_of(WIDTH, CHUNK);
    localparam logic [STAGES-1:0] TOP = STAGES'(1) << (STAGES - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_width
        $error("add_pipe: WIDTH must be a multiple of CHUNK");
    end

    logic              adv;
    logic [STAGES:0]   v;
    logic [STAGES:0]   c;
    logic [STAGES-1:0] cnx;
    logic [STAGES-1:0] cms;
    logic              ovf_q;

    assign adv       = !(v[STAGES] && !out_ready);
    assign in_ready  = adv;
    assign out_valid = v[STAGES];
    assign cout      = c[STAGES];
    assign ovf       = ovf_q;

    // c[0] is the effective carry-in captured with the operands
    always_ff @(posedge clk) begin
        if (rst) begin
            v     <= '0;
            c     <= '0;
            ovf_q <= 1'b0;
        end else if (adv) begin
            v     <= {v[STAGES-1:0], in_valid};
            c     <= {cnx, cin ^ sub};
            ovf_q <= (|(cms & TOP)) ^ cnx[STAGES-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        logic [CHUNK-1:0] ak [0:k];
        logic [CHUNK-1:0] bk [0:k];
        logic [CHUNK-1:0] dk [0:STAGES-1-k];
        logic [CHUNK-1:0] sum;
        logic             co;
        logic             cm;

        add_chunk #(.W(CHUNK)) u_add (
            .a     (ak[k]),
            .b     (bk[k]),
            .cin   (c[k]),
            .s     (sum),
            .cout  (co),
            .c_msb (cm)
        );

        assign cnx[k] = co;
        assign cms[k] = cm;
        assign s[k*CHUNK +: CHUNK] = dk[STAGES-1-k];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i <= k; i++) begin
                    ak[i] <= '0;
                    bk[i] <= '0;
                end
                for (int i = 0; i < STAGES - k; i++) begin
                    dk[i] <= '0;
                end
            end else if (adv) begin
                ak[0] <= a[k*CHUNK +: CHUNK];
                bk[0] <= b[k*CHUNK +: CHUNK] ^ {CHUNK{sub}};
                for (int i = 1; i <= k; i++) begin
                    ak[i] <= ak[i-1];
                    bk[i] <= bk[i-1];
                end
                dk[0] <= sum;
                for (int i = 1; i < STAGES - k; i++) begin
                    dk[i] <= dk[i-1];
                end
            end
        end
    end
endmodule
